// File: rtl/microsequencer_stack.sv
// Registered LC-3 style microsequencer with an optional microcode return stack.
// Define MICROSEQUENCER_STACK_EN to build the return stack and call/ret handling.
module microsequencer_stack #(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned OP_W        = 4,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_ADDR  = 18
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic [ADDR_W-1:0]              j,
   input  logic [2:0]                     cond,
   input  logic                           ird,
   input  logic                           call,
   input  logic                           ret,
   input  logic [OP_W-1:0]                ir_op,
   input  logic                           ir_11,
   input  logic                           r,
   input  logic                           ben,
   input  logic                           psr_15,
   input  logic                           int_req,
   output logic [ADDR_W-1:0]              next_addr,
   output logic [ADDR_W-1:0]              state,
   output logic [$clog2(STACK_DEPTH):0]   stk_depth,
   output logic                           stk_ovf,
   output logic                           stk_unf
);

   logic [ADDR_W-1:0] r_state;
   logic [ADDR_W-1:0] w_cj;
   logic [ADDR_W-1:0] w_op_addr;

   // Condition-modified J field: one status bit ORed into a cond-selected position
   always_comb begin
      w_cj = j;
      case (cond)
         3'd1:    w_cj[1] = j[1] | r;
         3'd2:    w_cj[2] = j[2] | ben;
         3'd3:    w_cj[0] = j[0] | ir_11;
         3'd4:    w_cj[3] = j[3] | psr_15;
         3'd5:    w_cj[4] = j[4] | int_req;
         default: w_cj    = j;
      endcase
   end

   assign w_op_addr = ADDR_W'(ir_op);

`ifdef MICROSEQUENCER_STACK_EN
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
   localparam int unsigned DEP_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
   logic [DEP_W-1:0]  r_depth;
   logic              r_ovf;
   logic              r_unf;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_ovf_ev;
   logic              w_unf_ev;
   logic [PTR_W-1:0]  w_top_idx;
   logic [PTR_W-1:0]  w_wr_idx;

   assign w_full    = (r_depth == DEP_W'(STACK_DEPTH));
   assign w_empty   = (r_depth == '0);
   assign w_top_idx = PTR_W'(r_depth - DEP_W'(1));
   assign w_wr_idx  = PTR_W'(r_depth);

   // ird overrides both stack ops; ret overrides call
   assign w_push   = en & ~ird & ~ret & call & ~w_full;
   assign w_ovf_ev = en & ~ird & ~ret & call &  w_full;
   assign w_pop    = en & ~ird &  ret & ~w_empty;
   assign w_unf_ev = en & ~ird &  ret &  w_empty;

   always_comb begin
      next_addr = w_cj;
      if (ird)
         next_addr = w_op_addr;
      else if (ret && !w_empty)
         next_addr = r_stack[w_top_idx];
   end

   // Stack contents need no reset; a write coinciding with reset is suppressed
   always_ff @(posedge clk) begin
      if (w_push && !reset)
         r_stack[w_wr_idx] <= r_state + ADDR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_push)
            r_depth <= r_depth + DEP_W'(1);
         else if (w_pop)
            r_depth <= r_depth - DEP_W'(1);
         if (w_ovf_ev)
            r_ovf <= 1'b1;
         if (w_unf_ev)
            r_unf <= 1'b1;
      end
   end

   assign stk_depth = r_depth;
   assign stk_ovf   = r_ovf;
   assign stk_unf   = r_unf;
`else
   logic w_unused;

   assign w_unused  = ^{call, ret};
   assign next_addr = ird ? w_op_addr : w_cj;
   assign stk_depth = '0;
   assign stk_ovf   = 1'b0;
   assign stk_unf   = 1'b0;
`endif

   // Current control-store state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ADDR_W'(RESET_ADDR);
      else if (en)
         r_state <= next_addr;
   end

   assign state = r_state;

endmodule

// File: doc/microsequencer_stack.md
# microsequencer_stack

Parametrised, registered successor to the LC-3 microsequencer. The block holds the current control-store state. Each cycle it computes the next microcode address from the J field, the COND branch select, IRD dispatch, and an optional microcode return stack. It sits between the control store (which supplies j/cond/ird/call/ret) and the control-store address port (driven from `state`).

## Interface
- ADDR_W, 6, width of microcode address; must be ≥ 5 and ≥ OP_W
- OP_W, 4, width of IRD dispatch opcode (IR[15:12])
- STACK_DEPTH, 4, return-stack entries; power of two, ≥ 2
- RESET_ADDR, 18, state loaded by reset (LC-3 fetch state)

Ports:
- clk  input  1  clock; rising edge active
- reset  input  1  asynchronous, active-high
- en  input  1  advance enable; low = hold all state
- j  input  ADDR_W  microword J field
- cond  input  3  branch select
- ird  input  1  opcode dispatch
- call  input  1  microcode call
- ret  input  1  microcode return
- ir_op  input  OP_W  IR[15:12]
- ir_11  input  1  IR[11]
- r  input  1  memory ready
- ben  input  1  branch enable
- psr_15  input  1  privilege bit
- int_req  input  1  pending interrupt
- next_addr  output  ADDR_W  combinational next address
- state  output  ADDR_W  registered current state
- stk_depth  output  clog2(STACK_DEPTH)+1  entries in use
- stk_ovf  output  1  sticky push-when-full flag
- stk_unf  output  1  sticky pop-when-empty flag

## Operation
- The condition-modified J field (cj) equals j with one bit ORed in, selected by cond:
  - cond 0: no modification.
  - cond 1: bit1 |= r.
  - cond 2: bit2 |= ben.
  - cond 3: bit0 |= ir_11.
  - cond 4: bit3 |= psr_15.
  - cond 5: bit4 |= int_req.
  - cond 6–7: reserved, no modification.
- Next-address priority, highest first:
  - ird: next_addr = zero-extended ir_op.
  - ret: next_addr = top of stack; pop. If the stack is empty, next_addr = cj, no pop, and stk_unf is set.
  - call: next_addr = cj; push (state + 1) mod 2^ADDR_W. If the stack is full, the push is dropped, stk_ovf is set, and the jump still occurs.
  - Otherwise: next_addr = cj.
- Simultaneous inputs:
  - call and ret together: ret wins; no push.
  - ird with call or ret: ird wins; the stack is untouched.
- The stack is a LIFO held in registers with a depth counter. Push and pop take effect only on enabled edges.
- stk_ovf and stk_unf are sticky and are cleared only by reset.
- en low: state, stack, depth and flags all hold. next_addr still reflects the current inputs.

## Timing
- next_addr is purely combinational from the inputs, the stack top and state; latency 0.
- state <= next_addr on a rising clk edge when en = 1, giving one cycle of latency.
- A return in cycle N uses the stack top as it stood before cycle N. A call in cycle N+1 may push immediately after that pop.
- Reset (asynchronous assert, synchronous release), values:
  - state = RESET_ADDR
  - stk_depth = 0
  - stk_ovf = 0
  - stk_unf = 0
  - stack contents: don't-care
- Reset asserted mid-call or mid-return aborts the operation; no partial push remains.
- Depth boundaries: stk_depth reaches STACK_DEPTH at full and never exceeds it; it never goes below 0.

## Configuration
- MICROSEQUENCER_STACK_EN defined: the return stack, call/ret handling, stk_depth and the flags are all implemented as above.
- MICROSEQUENCER_STACK_EN undefined:
  - No stack storage is built and call/ret are ignored.
  - stk_depth, stk_ovf and stk_unf are tied to 0.
  - Next address is ird dispatch, else cj.

## Test plan
- Reset with state forced elsewhere -> state = 18, depth 0, both flags 0, all immediately on reset assertion without a clock edge.
- j = 6'h02, cond = 2, ben = 1, en = 1 -> next_addr = 6'h06; state = 6'h06 after one edge. Repeat with en = 0 -> state holds.
- ird = 1, ir_op = 4'hB, call = 1 -> next_addr = 6'h0B; depth unchanged.
- state = 6'h10, call = 1, j = 6'h30 -> state 6'h30 and depth 1. Then ret = 1 -> state 6'h11 and depth 0.
- Five consecutive calls with depth 4 -> stk_ovf = 1 at the fifth; depth stays 4. Four returns then yield the first four pushed addresses in LIFO order.
- ret with empty stack, j = 6'h21, cond = 1, r = 0 -> state 6'h21 and stk_unf = 1. The flag stays 1 until reset.
